// File: rtl/vga_sync_rx_pkg.sv
// Shared VGA 640x480 timing constants and receiver state encoding, used by the
// sync receiver and by the VGA driver that feeds it.
package vga_sync_rx_pkg;

  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_BP        = 48;
  localparam int VGA_H_ACTIVE    = 640;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_BP        = 33;
  localparam int VGA_V_ACTIVE    = 480;
  localparam int VGA_V_TOTAL     = 525;
  localparam logic VGA_SYNC_ACT  = 1'b0;
  localparam int VGA_LOCK_FRAMES = 2;

  localparam int CNT_W = 10;
  localparam int RGB_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_t;

endpackage

// File: rtl/vga_sync_rx_if.sv
// Bundle between a VGA driver/consumer (master) and the sync receiver (slave).
interface vga_sync_rx_if;
  import vga_sync_rx_pkg::*;

  logic             hsync;
  logic             vsync;
  logic [RGB_W-1:0] vga_rgb;
  logic [CNT_W-1:0] posx;
  logic [CNT_W-1:0] posy;
  logic [RGB_W-1:0] rgb_out;
  logic             pix_valid;
  logic             frame_start;
  logic             locked;
  logic             sync_err;
  logic [CNT_W-1:0] h_meas;
  logic [CNT_W-1:0] v_meas;

  modport master (
    output hsync, vsync, vga_rgb,
    input  posx, posy, rgb_out, pix_valid, frame_start, locked, sync_err, h_meas, v_meas
  );

  modport slave (
    input  hsync, vsync, vga_rgb,
    output posx, posy, rgb_out, pix_valid, frame_start, locked, sync_err, h_meas, v_meas
  );

endinterface

// File: rtl/vga_sync_rx_sync_edge_det.sv
// Detects the transition of a sync line into its asserted level; the previous
// copy powers up deasserted so a line held asserted through reset still edges.
module sync_edge_det
  import vga_sync_rx_pkg::*;
#(
  parameter logic SYNC_ACT = VGA_SYNC_ACT
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev_p0;

  always_ff @(posedge clk) begin
    if (rst) prev_p0 <= ~SYNC_ACT;
    else     prev_p0 <= level;
  end

  assign pulse = (prev_p0 != SYNC_ACT) && (level == SYNC_ACT);

endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: measures line/frame lengths, locks onto stable timing and
// reconstructs active-area pixel coordinates from hsync/vsync alone.
module vga_sync_rx
  import vga_sync_rx_pkg::*;
#(
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   H_ACTIVE    = VGA_H_ACTIVE,
  parameter int   H_TOTAL     = VGA_H_TOTAL,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter int   V_ACTIVE    = VGA_V_ACTIVE,
  parameter int   V_TOTAL     = VGA_V_TOTAL,
  parameter logic SYNC_ACT    = VGA_SYNC_ACT,
  parameter int   LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic         vga_clk,
  input  logic         rst,
  vga_sync_rx_if.slave bus
);

  localparam logic [CNT_W-1:0] H_ACT_LO = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_HI = CNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_ACT_LO = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_HI = CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] H_LEN    = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] V_LEN    = CNT_W'(V_TOTAL);
  localparam int               GOOD_W   = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_FRAMES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic              h_edge, v_edge;
  logic [CNT_W-1:0]  h_cnt, v_cnt, h_len, v_len;
  logic              h_seen, v_seen, v_pend, dirty;
  logic              reload, line_err, frame_err, wd_hit, active, pix_ok;
  rx_state_t         state, state_nxt;
  logic [GOOD_W-1:0] good_cnt, good_nxt, good_inc;

  logic [CNT_W-1:0]  h_meas_p1, v_meas_p1, posx_p1, posy_p1;
  logic [RGB_W-1:0]  rgb_p1;
  logic              vld_p1, frame_start_p1, sync_err_p1;

  sync_edge_det #(.SYNC_ACT(SYNC_ACT)) u_h_edge (
    .clk(vga_clk), .rst(rst), .level(bus.hsync), .pulse(h_edge)
  );

  sync_edge_det #(.SYNC_ACT(SYNC_ACT)) u_v_edge (
    .clk(vga_clk), .rst(rst), .level(bus.vsync), .pulse(v_edge)
  );

  // p0: raw sync edges against the current counters
  assign h_len     = sat_inc(h_cnt);
  assign v_len     = sat_inc(v_cnt);
  // A vsync edge only arms the frame; the line that carries it is the reload point.
  assign reload    = h_edge & (v_pend | v_edge);
  assign line_err  = h_edge & h_seen & (h_len != H_LEN);
  assign frame_err = reload & v_seen & (v_len != V_LEN);
  assign wd_hit    = ~h_edge & (h_cnt == CNT_MAX - 1'b1);
  assign active    = (h_cnt >= H_ACT_LO) && (h_cnt <= H_ACT_HI) &&
                     (v_cnt >= V_ACT_LO) && (v_cnt <= V_ACT_HI);
  assign pix_ok    = active && (state == ST_LOCKED);
  assign good_inc  = good_cnt + 1'b1;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      h_seen    <= 1'b0;
      v_seen    <= 1'b0;
      v_pend    <= 1'b0;
      dirty     <= 1'b0;
      h_meas_p1 <= '0;
      v_meas_p1 <= '0;
    end else begin
      h_cnt <= h_edge ? '0 : h_len;
      if (h_edge) h_seen <= 1'b1;
      if (h_edge && h_seen) h_meas_p1 <= h_len;
      if (reload) begin
        v_cnt  <= '0;
        v_pend <= 1'b0;
        v_seen <= 1'b1;
        dirty  <= 1'b0;
        if (v_seen) v_meas_p1 <= v_len;
      end else begin
        if (h_edge)   v_cnt  <= v_len;
        if (v_edge)   v_pend <= 1'b1;
        if (line_err) dirty  <= 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state    <= ST_SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  // A frame is clean only if no line inside it, nor its own length, was wrong.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    if (wd_hit) begin
      state_nxt = ST_SEARCH;
      good_nxt  = '0;
    end else begin
      case (state)
        ST_SEARCH: begin
          if (reload) begin
            state_nxt = ST_TRACK;
            good_nxt  = '0;
          end
        end
        ST_TRACK: begin
          if (line_err || frame_err || (reload && dirty)) begin
            good_nxt = '0;
          end else if (reload) begin
            if (good_inc >= GOOD_TGT) begin
              state_nxt = ST_LOCKED;
              good_nxt  = '0;
            end else begin
              good_nxt = good_inc;
            end
          end
        end
        ST_LOCKED: begin
          if (line_err || frame_err) begin
            state_nxt = ST_TRACK;
            good_nxt  = '0;
          end
        end
        default: begin
          state_nxt = ST_SEARCH;
          good_nxt  = '0;
        end
      endcase
    end
  end

  // p1: registered outputs
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      vld_p1         <= 1'b0;
      posx_p1        <= '0;
      posy_p1        <= '0;
      rgb_p1         <= '0;
      frame_start_p1 <= 1'b0;
      sync_err_p1    <= 1'b0;
    end else begin
      vld_p1         <= pix_ok;
      posx_p1        <= pix_ok ? h_cnt - H_ACT_LO : '0;
      posy_p1        <= pix_ok ? v_cnt - V_ACT_LO : '0;
      rgb_p1         <= pix_ok ? bus.vga_rgb : '0;
      frame_start_p1 <= reload && (state == ST_LOCKED);
      sync_err_p1    <= line_err | frame_err | wd_hit;
    end
  end

  assign bus.posx        = posx_p1;
  assign bus.posy        = posy_p1;
  assign bus.rgb_out     = rgb_p1;
  assign bus.pix_valid   = vld_p1;
  assign bus.frame_start = frame_start_p1;
  assign bus.sync_err    = sync_err_p1;
  assign bus.locked      = (state == ST_LOCKED);
  assign bus.h_meas      = h_meas_p1;
  assign bus.v_meas      = v_meas_p1;

endmodule

// File: doc/vga_sync_rx.md
VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameters: H_SYNC 96, H_BP 48, H_ACTIVE 640, H_TOTAL 800; V_SYNC 2, V_BP 33, V_ACTIVE 480, V_TOTAL 525; SYNC_ACT 0 (sync level when asserted); LOCK_FRAMES 2 (good frames needed to lock).
REQ-002 Ports: vga_clk in 1, the only clock; rst in 1, synchronous active-high reset.
REQ-003 hsync in 1 and vsync in 1, sync from the VGA driver.
REQ-004 vga_rgb in 3, pixel colour from the VGA driver.
REQ-005 posx out 10 and posy out 10, reconstructed active-area pixel coordinates.
REQ-006 rgb_out out 3, captured pixel; pix_valid out 1, high when rgb_out/posx/posy describe an active pixel.
REQ-007 frame_start out 1, one-cycle pulse; locked out 1, lock status.
REQ-008 sync_err out 1, one-cycle pulse on a timing violation; h_meas out 10 and v_meas out 10, last measured line/frame length.

Function
REQ-009 Sample hsync, vsync and vga_rgb on every vga_clk edge; keep a one-cycle previous copy of hsync and vsync for edge detection.
REQ-010 An hsync edge is previous != SYNC_ACT and current == SYNC_ACT; the vsync edge uses the same rule.
REQ-011 h_cnt loads 0 on the hsync-edge cycle and otherwise increments, saturating at 1023.
REQ-012 On each hsync edge (except the first after reset), h_meas loads h_cnt+1, saturating at 1023; a value != H_TOTAL marks a line error.
REQ-013 A vsync edge sets a pending flag; the next hsync edge (the same cycle counts) loads v_cnt to 0 and clears the flag; any other hsync edge increments v_cnt, saturating at 1023.
REQ-014 At a v_cnt reload, v_meas loads v_cnt+1 (none on the first frame); a value != V_TOTAL marks a frame error.
REQ-015 sync_err pulses one cycle after any line or frame error, or after a watchdog expiry.
REQ-016 Watchdog: h_cnt reaching 1023 forces state SEARCH and pulses sync_err once.
REQ-017 Active region: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] = [144,783] and v_cnt in [35,514].
REQ-018 Outputs are registered with latency 1: on the cycle after an active sample, posx = h_cnt-144, posy = v_cnt-35, rgb_out = sampled vga_rgb.
REQ-019 pix_valid = 1 only when the region is active and locked = 1; otherwise pix_valid = 0 and rgb_out = 0.
REQ-020 FSM states:
- SEARCH: leave to TRACK on a v_cnt reload.
- TRACK: count consecutive error-free frames at each reload; at LOCK_FRAMES go to LOCKED; any error clears the count.
- LOCKED: any line or frame error goes to TRACK with count 0.
REQ-021 locked = 1 exactly while in LOCKED.
REQ-022 frame_start pulses one cycle after each v_cnt reload while in LOCKED.
REQ-023 Simultaneous hsync and vsync edges are handled as in REQ-013: one reload, no extra increment.

Reset
REQ-024 While rst = 1 at a vga_clk edge:
- posx, posy, rgb_out, pix_valid, frame_start, sync_err, locked = 0;
- h_meas, v_meas, h_cnt, v_cnt = 0;
- state SEARCH, good count 0, pending flag 0;
- previous sync copies = !SYNC_ACT.
REQ-025 Reset mid-frame discards all measurement; the first hsync edge after reset produces no h_meas update and no error.

Structure
REQ-026 The timing constants (REQ-001 values) and the FSM state encoding live in a shared package, also used by the VGA driver.
REQ-027 One sub-module, sync_edge_det, is instantiated twice (hsync, vsync); it holds the previous-copy register and outputs the edge pulse.

Verification
REQ-028 Drive the driver's nominal 800x525 timing for 3 frames from reset -> locked rises at the third v_cnt reload; no sync_err.
REQ-029 When locked, inject rgb = 3'b101 at h_cnt 144, v_cnt 35 -> next cycle pix_valid = 1, posx = 0, posy = 0, rgb_out = 3'b101; h_cnt 143 -> pix_valid = 0.
REQ-030 When locked, shorten one line to 799 cycles -> h_meas = 799, one sync_err pulse, locked falls; 2 good frames later locked = 1 again.
REQ-031 Hold hsync deasserted for 1100 cycles -> sync_err pulses once at h_cnt 1023; state SEARCH; locked = 0.
REQ-032 Assert vsync and hsync edges in the same cycle -> v_cnt = 0; v_meas = 525; no double count.
REQ-033 Assert rst mid-line while locked -> next cycle all outputs 0 and locked = 0; relock follows REQ-028 timing.
